// File: rtl/peripheral_mpram_wb_master.sv
// Wishbone burst initiator: turns one command (1..16 beats, fixed select) into
// incrementing classic-cycle beats with burst tags, a per-beat timeout and a done/err pulse.
module peripheral_mpram_wb_master #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  // Command side
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [3:0]    cmd_len_i,
  input  logic [3:0]    cmd_sel_i,
  // Write beat stream
  input  logic [DW-1:0] wdat_i,
  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  // Read beat stream and completion
  output logic [DW-1:0] rdat_o,
  output logic          rdat_valid_o,
  output logic          done_o,
  output logic          err_o,
  // Wishbone initiator
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  // Current FSM state for debug/observation
  output logic [1:0]    dbg_state_o
);

  // Handshakes: a command transfers on a rising edge where cmd_valid_i and
  // cmd_ready_o are both high, a write beat where wdat_valid_i and wdat_ready_o
  // are both high; rdat_valid_o and done_o are single-cycle strobes with no
  // backpressure. Both ready outputs are registered.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WFILL    = 2'd1,
    S_ACTIVE   = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

  localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    CTI_INC  = 3'b010;
  localparam logic [2:0]    CTI_END  = 3'b111;

  state_t        r_state;
  logic          r_cmd_ready;
  logic          r_wdat_ready;
  logic [DW-1:0] r_rdat;
  logic          r_rdat_valid;
  logic          r_done;
  logic          r_err;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat;
  logic [3:0]    r_sel;
  logic          r_we;
  logic [2:0]    r_cti;
  logic          r_cyc;
  logic          r_stb;
  logic [3:0]    r_len;
  logic [3:0]    r_beat;
  logic [TW-1:0] r_tmo;

  logic w_ack;
  logic w_fault;
  logic w_last;

  // Responses only count while a strobe is out; ack together with err is an error.
  assign w_ack   = r_stb & wb_ack_i & ~wb_err_i;
  assign w_fault = r_stb & (wb_err_i | (~wb_ack_i & (r_tmo == TMO_LAST)));
  assign w_last  = (r_beat == r_len);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_wdat_ready <= 1'b0;
      r_rdat       <= '0;
      r_rdat_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= 4'h0;
      r_we         <= 1'b0;
      r_cti        <= 3'b000;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_len        <= 4'd0;
      r_beat       <= 4'd0;
      r_tmo        <= '0;
    end else begin
      r_rdat_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid_i && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_we        <= cmd_we_i;
            r_adr       <= cmd_adr_i;
            r_len       <= cmd_len_i;
            r_sel       <= cmd_sel_i;
            r_beat      <= 4'd0;
            r_cti       <= (cmd_len_i == 4'd0) ? CTI_END : CTI_INC;
            r_cyc       <= 1'b1;
            r_tmo       <= '0;
            if (cmd_we_i) begin
              r_wdat_ready <= 1'b1;
              r_state      <= S_WFILL;
            end else begin
              r_stb   <= 1'b1;
              r_state <= S_ACTIVE;
            end
          end
        end
        S_WFILL: begin
          if (wdat_valid_i && r_wdat_ready) begin
            r_dat        <= wdat_i;
            r_wdat_ready <= 1'b0;
            r_stb        <= 1'b1;
            r_tmo        <= '0;
            r_state      <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_fault) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_COMPLETE;
          end else if (w_ack) begin
            if (!r_we) begin
              r_rdat       <= wb_dat_i;
              r_rdat_valid <= 1'b1;
            end
            if (w_last) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_COMPLETE;
            end else begin
              r_adr  <= r_adr + 1'b1;
              r_beat <= r_beat + 4'd1;
              r_cti  <= ((r_beat + 4'd1) == r_len) ? CTI_END : CTI_INC;
              r_tmo  <= '0;
              if (r_we) begin
                r_stb        <= 1'b0;
                r_wdat_ready <= 1'b1;
                r_state      <= S_WFILL;
              end
            end
          end else if (r_stb) begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_COMPLETE: begin
          // COMPLETE has cyc low, which guarantees an idle bus cycle between bursts.
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = r_cmd_ready;
  assign wdat_ready_o = r_wdat_ready;
  assign rdat_o       = r_rdat;
  assign rdat_valid_o = r_rdat_valid;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_sel_o     = r_sel;
  assign wb_we_o      = r_we;
  assign wb_bte_o     = 2'b00;
  assign wb_cti_o     = r_cti;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_stb;
  assign dbg_state_o  = r_state;

endmodule
